// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter and the blocks that consume its
// PERIOD output (speed estimation uses the same default width and limit).
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALLED = 2'd2
  } pm_state_e;

  localparam int PM_W_DEFAULT          = 16;
  localparam int PM_MIN_PERIOD_DEFAULT = 4;
  localparam int PM_TIMEOUT_DEFAULT    = 65535;

endpackage

// File: rtl/period_meter_if.sv
// Measurement bus of the period meter: enable and raw signal in, period
// result, strobes and stall level out.
interface period_meter_if #(
  parameter int W = period_meter_pkg::PM_W_DEFAULT
);
  logic         EN;
  logic         SIG_IN;
  logic [W-1:0] PERIOD;
  logic         PERIOD_VALID;
  logic         EDGE_PULSE;
  logic         REJECT;
  logic         TIMEOUT;

  // Controller side: drives enable and the signal, observes results.
  modport master (
    output EN, SIG_IN,
    input  PERIOD, PERIOD_VALID, EDGE_PULSE, REJECT, TIMEOUT
  );

  // Meter side.
  modport slave (
    input  EN, SIG_IN,
    output PERIOD, PERIOD_VALID, EDGE_PULSE, REJECT, TIMEOUT
  );
endinterface

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input followed by a third flop
// for rising-edge detection. RISE is high for one cycle when the
// synchronised input goes 0 -> 1. Reusable for the hall inputs.
module sync_edge_detect (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic RISE
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // Synchroniser chain plus the history flop used by the edge detector.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= D;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign RISE = sync2_q & ~sync3_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts CLK cycles between rising edges of an external square
// wave, rejects edges that come too early as glitches and reports a stall
// when no edge arrives within TIMEOUT_CYC cycles.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int W           = PM_W_DEFAULT,
  parameter int MIN_PERIOD  = PM_MIN_PERIOD_DEFAULT,
  parameter int TIMEOUT_CYC = PM_TIMEOUT_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  period_meter_if.slave bus
);

  localparam logic [W-1:0] MIN_CNT = W'(MIN_PERIOD);
  localparam logic [W-1:0] TMO_CNT = W'(TIMEOUT_CYC);
  localparam logic [W-1:0] ONE_CNT = W'(1);

  logic      rise;
  pm_state_e state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] period_q;
  logic      valid_q;
  logic      edge_q;
  logic      reject_q;
  logic      timeout_q;

  // The synchroniser runs independently of EN so re-enabling while SIG_IN is
  // already high cannot produce a false edge.
  sync_edge_detect u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .D    (bus.SIG_IN),
    .RISE (rise)
  );

  // Measurement FSM, cycle counter and registered outputs. The counter holds
  // the number of cycles since the last reference edge, so an edge seen with
  // counter value N means the period is N. It saturates at TIMEOUT_CYC.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      edge_q    <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      edge_q   <= 1'b0;
      reject_q <= 1'b0;
      if (!bus.EN) begin
        // Disabled: drop any partial count; PERIOD keeps its last value.
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        edge_q <= rise;
        unique case (state_q)
          ST_IDLE: begin
            if (rise) begin
              state_q <= ST_MEASURE;
              cnt_q   <= ONE_CNT;
            end else begin
              cnt_q <= '0;
            end
          end
          ST_MEASURE: begin
            if (rise && (cnt_q >= MIN_CNT)) begin
              // Accepted edge; also wins over a simultaneous timeout.
              period_q  <= cnt_q;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
              cnt_q     <= ONE_CNT;
            end else begin
              if (rise) begin
                reject_q <= 1'b1;
              end
              if (cnt_q >= TMO_CNT) begin
                state_q   <= ST_STALLED;
                timeout_q <= 1'b1;
                cnt_q     <= TMO_CNT;
              end else begin
                cnt_q <= cnt_q + ONE_CNT;
              end
            end
          end
          ST_STALLED: begin
            // The first edge after a stall only re-primes; TIMEOUT stays up
            // until a period is actually measured.
            if (rise) begin
              state_q <= ST_MEASURE;
              cnt_q   <= ONE_CNT;
            end else begin
              cnt_q <= TMO_CNT;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.PERIOD       = period_q;
  assign bus.PERIOD_VALID = valid_q;
  assign bus.EDGE_PULSE   = edge_q;
  assign bus.REJECT       = reject_q;
  assign bus.TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: directed scenarios plus randomized waveforms,
// every cycle compared against an event-time reference model.
module tb_period_meter;

  localparam int W    = 16;
  localparam int MINP = 4;
  localparam int TMO  = 100;

  logic clk;
  logic rst;

  period_meter_if #(.W(W)) bus ();

  period_meter #(
    .W           (W),
    .MIN_PERIOD  (MINP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: works on absolute cycle numbers of detected edges.
  int       n = 0;
  int       ref_t = 0;
  int       mode = 0;            // 0 not primed, 1 measuring, 2 stalled
  logic     h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;  // SIG_IN samples n-1, n-2, n-3
  logic [W-1:0] m_period = '0;
  logic     m_valid = 1'b0, m_edge = 1'b0, m_rej = 1'b0, m_tmo = 1'b0;

  task automatic model_step();
    logic r;
    int   el;
    n = n + 1;
    r = h2 & ~h3;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      mode = 0; m_period = '0;
      m_valid = 1'b0; m_edge = 1'b0; m_rej = 1'b0; m_tmo = 1'b0;
    end else begin
      h3 = h2; h2 = h1; h1 = bus.SIG_IN;
      m_valid = 1'b0; m_edge = 1'b0; m_rej = 1'b0;
      if (!bus.EN) begin
        mode = 0; m_tmo = 1'b0;
      end else begin
        m_edge = r;
        if (r) begin
          if (mode == 1) begin
            el = n - ref_t;
            if (el < MINP) m_rej = 1'b1;
            else begin
              m_period = W'(el); m_valid = 1'b1; m_tmo = 1'b0; ref_t = n;
            end
          end else begin
            mode = 1; ref_t = n;
          end
        end else if (mode == 1 && (n - ref_t) == TMO) begin
          mode = 2; m_tmo = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    tests++;
    assert (bus.PERIOD === m_period) else begin
      fails++; $error("FAIL period cyc=%0d got=%0d exp=%0d", n, bus.PERIOD, m_period);
    end
    tests++;
    assert (bus.PERIOD_VALID === m_valid) else begin
      fails++; $error("FAIL period_valid cyc=%0d got=%b exp=%b", n, bus.PERIOD_VALID, m_valid);
    end
    tests++;
    assert (bus.EDGE_PULSE === m_edge) else begin
      fails++; $error("FAIL edge_pulse cyc=%0d got=%b exp=%b", n, bus.EDGE_PULSE, m_edge);
    end
    tests++;
    assert (bus.REJECT === m_rej) else begin
      fails++; $error("FAIL reject cyc=%0d got=%b exp=%b", n, bus.REJECT, m_rej);
    end
    tests++;
    assert (bus.TIMEOUT === m_tmo) else begin
      fails++; $error("FAIL timeout cyc=%0d got=%b exp=%b", n, bus.TIMEOUT, m_tmo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(input logic v, input int cycles);
    bus.SIG_IN = v;
    repeat (cycles) tick();
  endtask

  task automatic wave(input int period, input int high, input int count);
    repeat (count) begin
      hold(1'b1, high);
      hold(1'b0, period - high);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.EN = 1'b0;
    bus.SIG_IN = 1'b0;
    #1;
    do_reset();
    check_val("reset_period", int'(bus.PERIOD), 0);
    check_val("reset_timeout", int'(bus.TIMEOUT), 0);

    // Latency: rise sampled at edge k gives EDGE_PULSE after edge k+2.
    bus.EN = 1'b1;
    hold(1'b0, 5);
    bus.SIG_IN = 1'b1;
    tick();
    check_val("latency_k", int'(bus.EDGE_PULSE), 0);
    tick();
    check_val("latency_k1", int'(bus.EDGE_PULSE), 0);
    tick();
    check_val("latency_k2", int'(bus.EDGE_PULSE), 1);
    check_val("latency_prime_novalid", int'(bus.PERIOD_VALID), 0);
    hold(1'b1, 7);
    hold(1'b0, 10);

    // Regular wave of period 20.
    wave(20, 10, 6);
    check_val("regular_period", int'(bus.PERIOD), 20);
    check_val("regular_timeout", int'(bus.TIMEOUT), 0);

    // Glitch two cycles after an edge.
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 17);
    wave(20, 10, 3);
    check_val("glitch_period", int'(bus.PERIOD), 20);

    // Stall then recovery with a 30-cycle period.
    wave(20, 10, 3);
    hold(1'b1, 10);
    hold(1'b0, 130);
    check_val("stall_timeout", int'(bus.TIMEOUT), 1);
    wave(30, 10, 1);
    check_val("stall_after_prime", int'(bus.TIMEOUT), 1);
    wave(30, 10, 2);
    check_val("stall_recover_period", int'(bus.PERIOD), 30);
    check_val("stall_recover_timeout", int'(bus.TIMEOUT), 0);

    // Boundary: edges exactly TMO apart, then TMO+1 apart.
    wave(100, 1, 3);
    check_val("boundary_period", int'(bus.PERIOD), 100);
    check_val("boundary_no_stall", int'(bus.TIMEOUT), 0);
    wave(101, 1, 2);
    check_val("boundary_plus1_stall", int'(bus.TIMEOUT), 1);

    // EN dropped 10 cycles after an edge, restored 5 cycles later.
    wave(20, 10, 3);
    hold(1'b1, 10);
    bus.EN = 1'b0;
    hold(1'b0, 5);
    bus.EN = 1'b1;
    hold(1'b0, 5);
    wave(20, 10, 3);
    check_val("en_restore_period", int'(bus.PERIOD), 20);

    // Reset mid-count.
    wave(20, 10, 2);
    hold(1'b1, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_mid_period", int'(bus.PERIOD), 0);
    check_val("rst_mid_valid", int'(bus.PERIOD_VALID), 0);
    check_val("rst_mid_timeout", int'(bus.TIMEOUT), 0);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Randomized waveforms with occasional enable drops and resets.
    for (int i = 0; i < 120; i++) begin
      int hi, lo, r;
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 115);
      r  = $urandom_range(0, 19);
      if (r == 0) bus.EN = 1'b0;
      else if (r < 4) bus.EN = 1'b1;
      else if (r == 4) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      hold(1'b1, hi);
      hold(1'b0, lo);
      bus.EN = 1'b1;
    end
    hold(1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an external square wave (e.g. hall-sensor or commutation feedback) in CLK cycles. This is the inverse of the clock divider: the divider derives a frequency from CLK, and this block recovers a cycle count from a frequency.
- Feeds speed estimation and stall detection in the BLDC controller.
- Includes input synchronisation, glitch rejection and timeout/stall reporting.

Parameters:
- W, 16, width of the period counter and of the PERIOD output.
- MIN_PERIOD, 4, minimum accepted period in CLK cycles; earlier edges are rejected as glitches.
- TIMEOUT_CYC, 65535, count at which a missing edge is declared a stall; must be ≤ 2^W-1 and > MIN_PERIOD.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  measurement enable.
- SIG_IN  in  1  asynchronous external signal.
- PERIOD  out  W  last accepted period, in CLK cycles.
- PERIOD_VALID  out  1  one-cycle strobe; PERIOD updated this cycle.
- EDGE_PULSE  out  1  one-cycle strobe on every detected rising edge, accepted or not.
- REJECT  out  1  one-cycle strobe; edge discarded as a glitch.
- TIMEOUT  out  1  level; stall detected, no edge within TIMEOUT_CYC.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RST.
- Reset, evaluated on the CLK rising edge: PERIOD=0, PERIOD_VALID=0, EDGE_PULSE=0, REJECT=0, TIMEOUT=0, state=IDLE, counter=0, synchroniser flops=0.
- Reset mid-measurement discards any partial count; no strobe is emitted.
- Synchroniser: 2 flops on SIG_IN plus a third flop for edge detection.
  - Rising edge is detected when sync2=1 and sync3=0.
  - A SIG_IN rise sampled at clock edge k gives EDGE_PULSE high in the cycle after edge k+2.
  - EDGE_PULSE, PERIOD_VALID and REJECT are registered and aligned in the same cycle.
- States:
  - IDLE: counter=0. On an edge with EN=1 → MEASURE, counter=1, no PERIOD_VALID.
  - MEASURE: counter increments each cycle.
    - Edge with counter ≥ MIN_PERIOD: PERIOD←counter, PERIOD_VALID=1, TIMEOUT←0, counter←1.
    - Edge with counter < MIN_PERIOD: REJECT=1, counter keeps incrementing, PERIOD unchanged.
    - counter reaches TIMEOUT_CYC with no edge in that cycle: → STALLED, TIMEOUT←1.
  - STALLED: counter holds at TIMEOUT_CYC. On an edge → MEASURE, counter=1, no PERIOD_VALID. TIMEOUT stays 1 until the next PERIOD_VALID.
- Period definition: edges detected at cycles t and t+N give PERIOD=N. A square wave of exactly N CLK cycles reads N.
- Simultaneous events:
  - Edge in the same cycle the counter equals TIMEOUT_CYC: the edge wins. PERIOD=TIMEOUT_CYC, PERIOD_VALID=1, no stall.
  - EN=0 in the same cycle as an edge: EN wins; the edge is ignored.
- EN=0 from any state: → IDLE next cycle, counter=0, TIMEOUT←0, PERIOD held, no strobes. Re-enable needs one priming edge before the next PERIOD_VALID.
- Counter arithmetic is unsigned W-bit and never wraps; it saturates at TIMEOUT_CYC.
- The synchroniser runs regardless of EN, so no false edge appears on re-enable when SIG_IN is already high.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_MEASURE=2'd1, ST_STALLED=2'd2), plus default W and TIMEOUT_CYC so the speed-calculation block uses matching widths.
- One sub-module: sync_edge_detect (2-flop synchroniser + rising-edge strobe, inputs CLK/RST/D, output RISE), reusable for hall inputs.
- FSM and counter live in period_meter.

Test Plan:
- Regular wave: RST released, EN=1, SIG_IN square wave of period 20 CLK → first edge gives no PERIOD_VALID; every later edge gives PERIOD=20 and a PERIOD_VALID pulse; TIMEOUT=0.
- Glitch: period 20 wave plus an extra 1-cycle-wide SIG_IN pulse 2 cycles after an edge → REJECT=1 once, EDGE_PULSE on the glitch, next valid PERIOD=20 (not 18); MIN_PERIOD=4.
- Stall (TIMEOUT_CYC=100): edges every 20 cycles, then SIG_IN held low → TIMEOUT rises exactly 100 cycles after the last edge. Next edge gives no PERIOD_VALID. The edge after that, 30 cycles later, gives PERIOD=30 and TIMEOUT=0.
- Boundary (TIMEOUT_CYC=100): two edges exactly 100 cycles apart → PERIOD=100, PERIOD_VALID=1, TIMEOUT stays 0. Edges 101 apart → TIMEOUT=1, no PERIOD_VALID.
- EN/reset mid-measurement: EN dropped 10 cycles after an edge and restored 5 cycles later → no strobes while low; the first edge after restore only primes; the second gives the correct period. RST asserted mid-count → all outputs 0 in the next cycle.
- Latency: a single SIG_IN rise sampled at edge k → EDGE_PULSE high in the cycle after edge k+2, checked cycle-exactly.
